// File: rtl/branch_pkg.sv
// Shared types and constants for the branch redirect controller and its tracking queue.
package branch_pkg;

  localparam int unsigned INST_BYTES = 4;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } ctrl_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] pred_addr;
  } track_entry_t;

  function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
    return pc + 32'(INST_BYTES);
  endfunction

endpackage

// File: rtl/pred_track_fifo.sv
// In-order queue of fetch-stage predictions awaiting resolution in execute.
module pred_track_fifo
  import branch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         push_i,
  input  track_entry_t wdata_i,
  input  logic         pop_i,
  output track_entry_t head_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  track_entry_t    mem_q [DEPTH];
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [PW-1:0]   rptr_q, rptr_d;
  logic [PW:0]     count_q, count_d;
  logic            do_push, do_pop;

  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rptr_q];

  // A push into a full queue is only legal when a pop frees the head slot in the same cycle.
  assign do_push = push_i & ~clr_i & (~full_o | pop_i);
  assign do_pop  = pop_i  & ~clr_i & ~empty_o;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (clr_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + 1'b1;
      if (do_pop)  rptr_d = rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Tracks fetch predictions, checks them at execute, and drives redirect/flush and predictor updates.
module branch_redirect_ctrl
  import branch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        f_fire,
  input  logic [31:0] f_pc,
  input  logic        f_predict_valid,
  input  logic [31:0] f_predict_addr,
  input  logic        x_valid,
  input  logic        x_is_branch,
  input  logic        x_taken,
  input  logic [31:0] x_target,
  output logic        f_stall,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        flush,
  output logic        upd_valid,
  output logic [31:0] upd_pc,
  output logic [31:0] upd_target,
  output logic        upd_taken,
  output logic [31:0] br_count,
  output logic [31:0] mp_count,
  output logic        q_err
);

  ctrl_state_e  state_q;
  track_entry_t head;
  track_entry_t fetch_entry;
  logic         in_run, q_full, q_empty;
  logic         pop_req, pop, pop_err, push;
  logic         br_taken, mispredict, need_upd;

  logic         redirect_valid_q, flush_q, upd_valid_q, upd_taken_q;
  logic         q_err_q, q_err_d;
  logic [31:0]  redirect_pc_q, redirect_pc_d;
  logic [31:0]  upd_pc_q, upd_target_q;
  logic [31:0]  br_count_q, br_count_d;
  logic [31:0]  mp_count_q, mp_count_d;

  assign in_run  = (state_q == RUN);
  assign pop_req = x_valid & in_run;
  assign pop     = pop_req & ~q_empty;
  assign pop_err = pop_req & q_empty;
  assign f_stall = q_full & ~pop;
  assign push    = f_fire & ~f_stall & in_run;

  assign fetch_entry.pc         = f_pc;
  assign fetch_entry.pred_taken = f_predict_valid;
  assign fetch_entry.pred_addr  = f_predict_addr;

  assign br_taken   = x_is_branch & x_taken;
  assign mispredict = pop & ((head.pred_taken != br_taken) |
                             (head.pred_taken & x_taken & (head.pred_addr != x_target)));
  // Non-branches that hit in the predictor are aliases and must be invalidated too.
  assign need_upd   = pop & (x_is_branch | head.pred_taken);

  pred_track_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (mispredict),
    .push_i  (push),
    .wdata_i (fetch_entry),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (q_full),
    .empty_o (q_empty)
  );

  always_comb begin
    redirect_pc_d = br_taken ? x_target : next_seq_pc(head.pc);
    br_count_d    = br_count_q + ((pop & x_is_branch) ? 32'd1 : 32'd0);
    mp_count_d    = mp_count_q + (mispredict ? 32'd1 : 32'd0);
    q_err_d       = q_err_q | pop_err;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= RUN;
      redirect_valid_q <= 1'b0;
      flush_q          <= 1'b0;
      upd_valid_q      <= 1'b0;
      upd_taken_q      <= 1'b0;
      redirect_pc_q    <= '0;
      upd_pc_q         <= '0;
      upd_target_q     <= '0;
      br_count_q       <= '0;
      mp_count_q       <= '0;
      q_err_q          <= 1'b0;
    end else begin
      redirect_valid_q <= 1'b0;
      flush_q          <= 1'b0;
      upd_valid_q      <= 1'b0;
      br_count_q       <= br_count_d;
      mp_count_q       <= mp_count_d;
      q_err_q          <= q_err_d;
      case (state_q)
        RUN: begin
          if (need_upd) begin
            upd_valid_q  <= 1'b1;
            upd_pc_q     <= head.pc;
            upd_target_q <= x_target;
            upd_taken_q  <= br_taken;
          end
          if (mispredict) begin
            state_q          <= FLUSH;
            redirect_valid_q <= 1'b1;
            flush_q          <= 1'b1;
            redirect_pc_q    <= redirect_pc_d;
          end
        end
        FLUSH: begin
          state_q <= RUN;
        end
        default: begin
          state_q <= RUN;
        end
      endcase
    end
  end

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign flush          = flush_q;
  assign upd_valid      = upd_valid_q;
  assign upd_pc         = upd_pc_q;
  assign upd_target     = upd_target_q;
  assign upd_taken      = upd_taken_q;
  assign br_count       = br_count_q;
  assign mp_count       = mp_count_q;
  assign q_err          = q_err_q;

endmodule

// File: doc/branch_redirect_ctrl.md
# branch_redirect_ctrl

Sequencing controller that sits between fetch, execute and the `branch_predictor` in the pipelined core. Records every fetch-stage prediction in an in-order tracking queue, checks it against the execute-stage outcome, and on a mismatch raises a registered redirect/flush. Drives the predictor update port for every resolved branch, including invalidation of aliased entries. Also keeps branch and mispredict counters for performance analysis.

## Interface
- `DEPTH`, 4: tracking-queue entries; power of two, 2..16.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `f_fire` in 1: an instruction leaves fetch this cycle.
- `f_pc` in 32: PC of that instruction.
- `f_predict_valid` in 1: predictor hit (predicted taken) for `f_pc`.
- `f_predict_addr` in 32: predicted target.
- `x_valid` in 1: execute resolves the oldest tracked instruction.
- `x_is_branch` in 1: resolved instruction is a branch/jump.
- `x_taken` in 1: branch was taken.
- `x_target` in 32: computed target.
- `f_stall` out 1: queue cannot accept a push.
- `redirect_valid` out 1: load `redirect_pc` into the fetch PC.
- `redirect_pc` out 32: correct next PC.
- `flush` out 1: kill the F and D stages.
- `upd_valid` out 1: write the predictor.
- `upd_pc` out 32, `upd_target` out 32, `upd_taken` out 1: predictor update payload.
- `br_count` out 32, `mp_count` out 32: resolved-branch and mispredict counters.
- `q_err` out 1: sticky; pop from an empty queue.

## Operation
- Entry = {pc, pred_taken, pred_addr}. Push on `f_fire & ~f_stall` while in RUN. Pop on `x_valid` while in RUN.
- `f_stall = full & ~pop`. A push and a pop in the same cycle are legal when full; the count is unchanged.
- Mispredict (evaluated on pop, against the head entry):
  - `pred_taken != (x_is_branch & x_taken)`, or
  - `pred_taken & x_taken & (pred_addr != x_target)`.
- `redirect_pc = (x_is_branch & x_taken) ? x_target : head.pc + 4`. The add wraps modulo 2^32.
- Predictor update, registered:
  - When: `x_is_branch`, or a non-branch with `pred_taken` (alias).
  - `upd_pc = head.pc`, `upd_target = x_target`, `upd_taken = x_is_branch & x_taken`. An alias gives `upd_taken = 0`, which invalidates the entry.
- `br_count` increments on each popped branch. `mp_count` increments on each mispredict. Both wrap.
- FSM states:
  - RUN -> FLUSH on a mispredict pop. In that same edge the queue is cleared (read/write pointers and count set to 0) and a push in that cycle is discarded.
  - FLUSH lasts exactly 1 cycle. `redirect_valid`, `flush` and `upd_valid` are high. `f_fire` and `x_valid` are ignored (wrong-path instructions). The state then returns to RUN.
- A correctly predicted pop stays in RUN, with `upd_valid` high for 1 cycle if an update is required.
- Pop with the queue empty: `q_err` is set, no other effect, and the FSM stays in RUN.
- Reset: all outputs 0, queue empty, state RUN, counters 0, `q_err` 0. Reset asserted mid-flush aborts the redirect immediately (asynchronous).

## Timing
- Pop at edge t; redirect, flush and update are visible in the cycle after edge t. Fetch samples `redirect_pc` at edge t+1.
- The first push accepted after a mispredict is at edge t+2.
- `f_stall` is combinational from count and `x_valid`. All other outputs are registered.
- Minimum mispredict penalty, excluding the pipeline stages themselves: 1 bubble cycle.

## Structure
- Shared package `branch_pkg`:
  - entry struct {pc, pred_taken, pred_addr};
  - FSM enum {RUN, FLUSH};
  - constant `INST_BYTES = 4`.
- One sub-module, `pred_track_fifo`: a DEPTH-entry synchronous FIFO with clear, full and empty. The controller holds the compare logic, FSM, update registers and counters.

## Test plan
- Fetch 0x1000, 0x1004, 0x1008 with no predictions; resolve all as non-branch -> no redirect, no update, `br_count` = 0.
- Push 0x100c with `f_predict_valid` = 1 and addr 0x1010; resolve taken to 0x1010 -> no redirect; `upd_valid` for 1 cycle with pc 0x100c, target 0x1010, taken; `br_count` = 1.
- Push 0x1014 unpredicted, then 0x1018; resolve 0x1014 taken to 0x1000 -> next cycle `redirect_pc` = 0x1000 with `flush` high; the queue empties; a push at the FLUSH cycle is dropped; `mp_count` = 1.
- Push 0x1008 predicted to 0x1010; resolve non-branch -> redirect to 0x100c, alias update with `upd_taken` = 0.
- Push 4 entries with no pops -> `f_stall` = 1. With `f_fire` and `x_valid` both high, count stays at 4 and head/tail advance correctly across pointer wrap.
- Drop `rst_n` during the FLUSH cycle -> all outputs 0 asynchronously. `x_valid` with the queue empty -> `q_err` = 1, which stays set.
